// File: rtl/fop_pkg.sv
// rtl/fop_pkg.sv - shared types and constants for the fop run sequencer (FOP_SEQ_WATCHDOG_EN adds S_ERR)
package fop_pkg;

    localparam int CNT_W            = 16;
    localparam int RESET_CYCLES_DEF = 1;
    localparam int WDOG_CYCLES_DEF  = 1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
`ifdef FOP_SEQ_WATCHDOG_EN
        , S_ERR
`endif
    } state_e;

endpackage

// File: rtl/fop_cnt.sv
// rtl/fop_cnt.sv - loadable saturating up-counter with terminal-match flag
module fop_cnt
    import fop_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] target,
    output logic         match
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // load wins over increment; increment stops at all-ones so the count never wraps
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match = (count_q == target);

endmodule

// File: rtl/fop_sequencer.sv
// rtl/fop_sequencer.sv - reset/enable run sequencer for a fop core; FOP_SEQ_WATCHDOG_EN enables the N=0 watchdog
module fop_sequencer
    import fop_pkg::*;
#(
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] run_cycles,
    input  logic        abort,
    input  logic        fop_done,
    output logic        fop_reset,
    output logic        fop_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             fop_reset_q, fop_reset_d;
    logic             fop_enable_q, fop_enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_d;

    logic             run_load, run_inc, run_match;
    logic [CNT_W-1:0] run_target;

    // one counter times the reset phase and then the run phase; both start at 1 on entry
    assign run_target = (state_q == S_RST) ? RST_LEN : run_len_q;

    fop_cnt #(.W(CNT_W)) u_run_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (run_load),
        .load_val (ONE),
        .inc      (run_inc),
        .target   (run_target),
        .match    (run_match)
    );

`ifdef FOP_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LEN = CNT_W'(WDOG_CYCLES);

    logic wd_load, wd_inc, wd_match, error_q;

    fop_cnt #(.W(CNT_W)) u_wd_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (ONE),
        .inc      (wd_inc),
        .target   (WD_LEN),
        .match    (wd_match)
    );
`else
    logic unused_wdog;
    assign unused_wdog = ^(32'(WDOG_CYCLES));
`endif

    // next-state, counter control and output decode; abort outranks fop_done, which outranks count/watchdog
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        run_load  = 1'b0;
        run_inc   = 1'b0;
`ifdef FOP_SEQ_WATCHDOG_EN
        wd_load   = 1'b0;
        wd_inc    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RST;
                    run_len_d = run_cycles;
                    run_load  = 1'b1;
                end
            end
            S_RST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (run_match) begin
                    state_d  = S_RUN;
                    run_load = 1'b1;
`ifdef FOP_SEQ_WATCHDOG_EN
                    wd_load  = 1'b1;
`endif
                end else begin
                    run_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fop_done || ((run_len_q != '0) && run_match)) begin
                    state_d = S_DONE;
`ifdef FOP_SEQ_WATCHDOG_EN
                end else if ((run_len_q == '0) && wd_match) begin
                    state_d = S_ERR;
`endif
                end else begin
                    run_inc = 1'b1;
`ifdef FOP_SEQ_WATCHDOG_EN
                    wd_inc  = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        fop_reset_d  = (state_d == S_RST);
        fop_enable_d = (state_d == S_RUN);
        busy_d       = (state_d == S_RST) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
`ifdef FOP_SEQ_WATCHDOG_EN
        error_d      = (state_d == S_ERR);
`else
        error_d      = 1'b0;
`endif
    end

    // state, latched run length and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            run_len_q    <= '0;
            fop_reset_q  <= 1'b0;
            fop_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FOP_SEQ_WATCHDOG_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            run_len_q    <= run_len_d;
            fop_reset_q  <= fop_reset_d;
            fop_enable_q <= fop_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef FOP_SEQ_WATCHDOG_EN
            error_q      <= error_d;
`endif
        end
    end

    assign fop_reset  = fop_reset_q;
    assign fop_enable = fop_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef FOP_SEQ_WATCHDOG_EN
    assign error      = error_q;
`else
    logic unused_error_d;
    assign unused_error_d = error_d;
    assign error          = 1'b0;
`endif

endmodule

// File: doc/fop_sequencer.md
FOP_SEQUENCER -- requirements
Module: fop_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 1: number of cycles fop_reset is held high per run (legal range 1..255).
REQ-002 SHALL have parameter WDOG_CYCLES, default 1000: watchdog limit in cycles (used only when FOP_SEQ_WATCHDOG_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a run sequence.
REQ-006 SHALL have port run_cycles, input, 16 bits: run length, sampled with start; 0 means run until fop_done.
REQ-007 SHALL have port abort, input, 1 bit: terminate the current sequence.
REQ-008 SHALL have port fop_done, input, 1 bit: completion indication from the controlled fop core.
REQ-009 SHALL have port fop_reset, output, 1 bit: reset drive to the fop core.
REQ-010 SHALL have port fop_enable, output, 1 bit: enable drive to the fop core.
REQ-011 SHALL have port busy, output, 1 bit: sequence in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking normal completion.
REQ-013 SHALL have port error, output, 1 bit: one-cycle pulse marking a watchdog expiry.

Function
REQ-014 SHALL implement an FSM with states IDLE, RST, RUN, DONE, ERR; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 SHALL latch run_cycles and enter RST at the next edge; busy SHALL rise with fop_reset.
REQ-016 In RST, fop_reset=1 and fop_enable=0 SHALL hold for exactly RESET_CYCLES cycles, then the FSM SHALL enter RUN.
REQ-017 On the edge that clears fop_reset, fop_enable SHALL go to 1, with no gap cycle.
REQ-018 In RUN with latched N>0, fop_enable SHALL remain high for exactly N cycles, then the FSM SHALL enter DONE.
REQ-019 In RUN, fop_done=1 SHALL end the run at the next edge (enter DONE), whichever of fop_done or the counter comes first.
REQ-020 In RUN with latched N=0, the run SHALL end only on fop_done, abort, or (with the watchdog) expiry.
REQ-021 In DONE, the FSM SHALL assert done=1 for one cycle with fop_enable=0 and busy=0, then return to IDLE.
REQ-022 The cycle counter SHALL be 16 bits, SHALL saturate, and SHALL never wrap; N=65535 SHALL yield 65535 enable cycles.
REQ-023 abort=1 in RST or RUN SHALL return the FSM to IDLE at the next edge with all outputs 0 and no done pulse.
REQ-024 abort=1 in IDLE or DONE SHALL be ignored.
REQ-025 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-026 If abort and fop_done arrive in the same cycle, abort SHALL take priority.
REQ-027 If fop_done arrives in the same cycle the counter reaches N, exactly one done pulse SHALL be produced.

Reset
REQ-028 reset=1 SHALL force IDLE at the next edge from any state, clearing the counter and latched length.
REQ-029 While reset=1, fop_reset, fop_enable, busy, done and error SHALL all be 0.
REQ-030 reset SHALL take priority over start, abort and fop_done.

Configuration
REQ-031 Macro FOP_SEQ_WATCHDOG_EN SHALL control the watchdog.
REQ-032 With FOP_SEQ_WATCHDOG_EN defined, a run with N=0 lasting WDOG_CYCLES without fop_done SHALL enter ERR.
REQ-033 In ERR, the FSM SHALL drop fop_enable, pulse error=1 for one cycle, then return to IDLE.
REQ-034 Without FOP_SEQ_WATCHDOG_EN, the ERR state and its counter SHALL be absent, error SHALL be tied 0, and an N=0 run SHALL wait indefinitely.

Structure
REQ-035 Package fop_pkg SHALL hold the state enum type, the constant CNT_W=16, and the default constants for RESET_CYCLES and WDOG_CYCLES.
REQ-036 A single sub-module fop_cnt (loadable saturating up-counter with terminal-match flag) SHALL be used for both the run counter and the watchdog counter.

Verification
REQ-037 The bench SHALL cover: reset, then start with run_cycles=4 and RESET_CYCLES=1 -> fop_reset high 1 cycle, fop_enable high exactly 4 cycles, one done pulse, busy low after.
REQ-038 The bench SHALL cover: run_cycles=0 with fop_done asserted at the 7th enable cycle -> enable drops next edge, one done pulse.
REQ-039 The bench SHALL cover: abort in the 2nd RUN cycle of a run_cycles=10 run -> IDLE next edge, no done, start re-accepted the following cycle.
REQ-040 The bench SHALL cover: reset=1 mid-RUN -> all outputs 0 at the next edge, and a subsequent start runs normally.
REQ-041 The bench SHALL cover: FOP_SEQ_WATCHDOG_EN defined, WDOG_CYCLES=20, run_cycles=0, no fop_done -> error pulse after 20 enable cycles; without the macro, enable stays high for at least 100 cycles.
REQ-042 The bench SHALL cover: start pulsed during RUN and during DONE -> ignored; fop_done and counter-match in the same cycle -> exactly one done pulse.
